w5300_rx_arbiter: RTL and testbench
===================================

Name: w5300_rx_arbiter

Overview:
- Multi-socket successor to the single-socket W5300 receive engine.
- Monitors RX interrupts from NUM_SOCKETS consecutive W5300 sockets and grants them round-robin.
- Per granted packet: reads the byte length from Sn_RX_FIFOR, drains the packet 16 bits per access into the RX buffer, then issues Sn_CR=RECV.
- Adds length clamping against buffer capacity, zero-length handling, a buffer-busy backpressure input and a per-packet completion record.
- Sits between the W5300 bus controller and the ethernet RX buffer.

Parameters:
SOCKET_BASE, 0, index of the first serviced socket (3-bit, SOCKET_BASE+NUM_SOCKETS ≤ 8)
NUM_SOCKETS, 2, number of serviced sockets, 1..8
ETH_RX_BUFFER_WIDTH, 16, RX buffer word-address width; capacity CAP = 2**ETH_RX_BUFFER_WIDTH 16-bit words

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_irq  in  NUM_SOCKETS  per-socket RX-pending level, bit i = socket SOCKET_BASE+i
buf_busy  in  1  RX buffer still owned by the consumer; no new packet starts while high
eth_rx_req  out  1  buffer write strobe; data and addr valid this cycle
eth_rx_buffer_data  out  16  FIFO word, equals rd_data
eth_rx_buffer_addr  out  ETH_RX_BUFFER_WIDTH  buffer word address, 0-based per packet
rx_done  out  1  one-cycle completion pulse
rx_sock  out  3  absolute socket number of the last packet, held until the next rx_done
rx_len  out  16  byte length of the last packet, held
rx_overflow  out  1  last packet exceeded CAP, held
addr  out  11  bus request: {dir bit (RD/WR from W5300 package), 10-bit register}
wr_data  out  16  bus write data
rd_data  in  16  bus read data, valid when op_state=1
op_state  in  1  bus controller completed the current access this cycle

Behaviour:
- Reset: state Idle; all outputs 0, except addr={RD,10'h3FE}.
- Any assertion of rst mid-packet returns to Idle and clears all state. The partially read socket is not RECV-committed; upper layer reopens it.
- States:
  - Idle: if |rx_irq && !buf_busy && op_state, latch the granted socket → ReadSize.
  - ReadSize: bus {RD, FIFOR(sock)}. On op_state, capture bytes=rd_data → Calc.
  - Calc: words=(bytes+1)>>1, computed 17-bit (0xFFFF→0x8000). Set overflow=(words>CAP).
    - words==0 → Recv.
    - else → ReadFifo.
  - ReadFifo: bus {RD, FIFOR(sock)}. On each op_state:
    - cnt++.
    - If cnt<CAP: eth_rx_req=1, write at addr=cnt, then addr advances.
    - Past CAP: words are discarded with eth_rx_req=0.
    - Leave when cnt reaches words → Recv.
  - Recv: bus {WR, CR(sock), Sn_CR_RECEIVE}. On op_state → Done.
  - Done: rx_done=1 for one cycle; update rx_sock/rx_len/rx_overflow; rotate priority → Idle.
- Idle bus request: {RD,10'h3FE}.
- eth_rx_req is asserted only on op_state cycles inside ReadFifo, so there is at most one strobe per bus access.
- Arbitration is round-robin:
  - Search starts at the socket after the last served one.
  - Priority pointer resets to socket SOCKET_BASE.
  - Simultaneous requests are served in rotating order; with all bits held high, no socket is starved beyond NUM_SOCKETS packets.
- rx_irq changes after grant are ignored until Done.
- Register addresses come from the package function get_socket_n_reg(reg, n) with n=SOCKET_BASE+grant.

Optional Feature:
W5300_RX_STATS_EN:
- Defined: adds outputs pkt_count[31:0] and ovf_count[15:0].
  - pkt_count increments at each rx_done.
  - ovf_count increments at rx_done when overflow=1.
  - Both saturate and are cleared by rst.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- W5300 package (existing) gains:
  - the state enum type w5300_rx_state_t;
  - IDLE_REG = 10'h3FE;
  - function rr_next(mask, last, n) returning the next grant index.
- One sub-module, w5300_rr_arbiter (request vector, advance strobe, grant index, any-valid), reused later by the transmit side.

Test Plan:
- Socket 0 irq, size word 6, data A1,A2,A3 → three eth_rx_req at addr 0,1,2; RECV written to CR(0); rx_done with rx_sock=0, rx_len=6, rx_overflow=0.
- Size 5 → 3 FIFO reads; rx_len=5.
- Size 0 → no eth_rx_req; RECV issued; rx_done with rx_len=0.
- rx_irq=2'b11 held for 4 packets → rx_sock sequence 0,1,0,1.
- ETH_RX_BUFFER_WIDTH=2, size 12 → 6 FIFO reads, 4 eth_rx_req at addr 0..3; rx_overflow=1; with W5300_RX_STATS_EN, ovf_count=1.
- buf_busy=1 with irq pending → stays Idle. rst pulsed during ReadFifo → next cycle Idle, outputs at reset values, no RECV issued.

Source files
------------

// File: rtl/w5300_rx_arbiter_pkg.sv
// W5300 register map helpers, receive-engine state type and round-robin search
// shared by the receive arbiter (and later the transmit side).
package w5300_rx_arbiter_pkg;

  localparam logic        W5300_RD      = 1'b1;
  localparam logic        W5300_WR      = 1'b0;
  localparam logic [9:0]  IDLE_REG      = 10'h3FE;
  localparam logic [15:0] SN_CR_RECEIVE = 16'h0040;

  typedef enum logic [1:0] {
    SN_REG_CR,
    SN_REG_RX_RSR,
    SN_REG_RX_FIFOR
  } w5300_sn_reg_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_READ_SIZE,
    RX_CALC,
    RX_READ_FIFO,
    RX_RECV,
    RX_DONE
  } w5300_rx_state_t;

  // Socket n register block lives at 0x200 + 0x40*n.
  function automatic logic [9:0] get_socket_n_reg(w5300_sn_reg_t r, logic [2:0] n);
    logic [9:0] off;
    case (r)
      SN_REG_CR:     off = 10'h002;
      SN_REG_RX_RSR: off = 10'h028;
      default:       off = 10'h030;
    endcase
    return 10'h200 + {1'b0, n, 6'b0} + off;
  endfunction

  // First set bit of mask after 'last', wrapping within n entries; descending
  // scan so the nearest candidate is the final assignment.
  function automatic logic [2:0] rr_next(logic [7:0] mask, logic [2:0] last, int n);
    logic [2:0] g;
    int         idx;
    g = last;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = int'(last) + k;
        if (idx >= n) idx = idx - n;
        if (mask[idx[2:0]]) g = idx[2:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/w5300_rx_arbiter_rr.sv
// Round-robin arbiter: grant is the first requester after the last granted index.
module w5300_rr_arbiter
  import w5300_rx_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [2:0]   grant_o,
  output logic         valid_o
);

  logic [2:0] last_q;
  logic [7:0] mask;

  always_comb begin
    mask          = '0;
    mask[N-1:0]   = req_i;
  end

  assign grant_o = rr_next(mask, last_q, N);
  assign valid_o = |req_i;

  // Pointer starts at the top entry so index 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst)        last_q <= 3'(N - 1);
    else if (adv_i) last_q <= grant_o;
  end

endmodule

// File: rtl/w5300_rx_arbiter.sv
// Multi-socket W5300 receive engine: round-robin socket grant, FIFO drain into
// the RX buffer, RECV commit. Optional counters under W5300_RX_STATS_EN.
module w5300_rx_arbiter
  import w5300_rx_arbiter_pkg::*;
#(
  parameter int SOCKET_BASE         = 0,
  parameter int NUM_SOCKETS         = 2,
  parameter int ETH_RX_BUFFER_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SOCKETS-1:0]         rx_irq,
  input  logic                           buf_busy,
  output logic                           eth_rx_req,
  output logic [15:0]                    eth_rx_buffer_data,
  output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
  output logic                           rx_done,
  output logic [2:0]                     rx_sock,
  output logic [15:0]                    rx_len,
  output logic                           rx_overflow,
  output logic [10:0]                    addr,
  output logic [15:0]                    wr_data,
  input  logic [15:0]                    rd_data,
  input  logic                           op_state
`ifdef W5300_RX_STATS_EN
  ,
  output logic [31:0]                    pkt_count,
  output logic [15:0]                    ovf_count
`endif
);

  localparam logic [31:0] CAP = 32'd1 << ETH_RX_BUFFER_WIDTH;

  w5300_rx_state_t state_q;
  logic [2:0]      sock_q;
  logic [15:0]     bytes_q;
  logic [16:0]     words_q, words_d;
  logic [16:0]     cnt_q;
  logic            ovf_q;
  logic [10:0]     addr_q;
  logic [15:0]     wr_data_q;
  logic            rx_done_q, rx_ovf_q;
  logic [2:0]      rx_sock_q;
  logic [15:0]     rx_len_q;

  logic [2:0]      grant;
  logic            grant_vld, start;
  logic [2:0]      grant_abs;
  logic [9:0]      fifor_reg, cr_reg;

  assign start     = (state_q == RX_IDLE) && grant_vld && !buf_busy && op_state;
  assign grant_abs = 3'(SOCKET_BASE) + grant;
  assign fifor_reg = get_socket_n_reg(SN_REG_RX_FIFOR, sock_q);
  assign cr_reg    = get_socket_n_reg(SN_REG_CR, sock_q);
  // 17-bit so a 0xFFFF byte count rounds up to 0x8000 words.
  assign words_d   = 17'(({1'b0, bytes_q} + 17'd1) >> 1);

  // Pointer advances at grant; nothing arbitrates again before Done returns to Idle.
  w5300_rr_arbiter #(.N(NUM_SOCKETS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req_i   (rx_irq),
    .adv_i   (start),
    .grant_o (grant),
    .valid_o (grant_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      sock_q    <= '0;
      bytes_q   <= '0;
      words_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      addr_q    <= {W5300_RD, IDLE_REG};
      wr_data_q <= '0;
      rx_done_q <= 1'b0;
      rx_sock_q <= '0;
      rx_len_q  <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (state_q)
        RX_IDLE: if (start) begin
          sock_q  <= grant_abs;
          addr_q  <= {W5300_RD, get_socket_n_reg(SN_REG_RX_FIFOR, grant_abs)};
          state_q <= RX_READ_SIZE;
        end
        RX_READ_SIZE: if (op_state) begin
          bytes_q <= rd_data;
          addr_q  <= {W5300_RD, IDLE_REG};
          state_q <= RX_CALC;
        end
        RX_CALC: begin
          words_q <= words_d;
          ovf_q   <= 32'(words_d) > CAP;
          cnt_q   <= '0;
          if (words_d == '0) begin
            addr_q    <= {W5300_WR, cr_reg};
            wr_data_q <= SN_CR_RECEIVE;
            state_q   <= RX_RECV;
          end else begin
            addr_q  <= {W5300_RD, fifor_reg};
            state_q <= RX_READ_FIFO;
          end
        end
        RX_READ_FIFO: if (op_state) begin
          cnt_q <= cnt_q + 17'd1;
          if (cnt_q + 17'd1 == words_q) begin
            addr_q    <= {W5300_WR, cr_reg};
            wr_data_q <= SN_CR_RECEIVE;
            state_q   <= RX_RECV;
          end
        end
        RX_RECV: if (op_state) begin
          addr_q    <= {W5300_RD, IDLE_REG};
          wr_data_q <= '0;
          rx_done_q <= 1'b1;
          rx_sock_q <= sock_q;
          rx_len_q  <= bytes_q;
          rx_ovf_q  <= ovf_q;
          state_q   <= RX_DONE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  // Strobe rides the bus completion; words past capacity are read and dropped.
  assign eth_rx_req         = (state_q == RX_READ_FIFO) && op_state && (32'(cnt_q) < CAP);
  assign eth_rx_buffer_data = eth_rx_req ? rd_data : '0;
  assign eth_rx_buffer_addr = eth_rx_req ? ETH_RX_BUFFER_WIDTH'(cnt_q) : '0;

  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign rx_done     = rx_done_q;
  assign rx_sock     = rx_sock_q;
  assign rx_len      = rx_len_q;
  assign rx_overflow = rx_ovf_q;

`ifdef W5300_RX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (rx_done_q) begin
      if (pkt_cnt_q != '1)             pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (rx_ovf_q && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_w5300_rx_arbiter.sv
// Bench for w5300_rx_arbiter: packet-level socket/bus model plus directed packets.
module tb_w5300_rx_arbiter;

  localparam int N   = 2;
  localparam int BW  = 2;
  localparam int CAP = 4;

  logic          clk = 1'b0, rst = 1'b1, buf_busy = 1'b0, op_state = 1'b0;
  logic [N-1:0]  rx_irq = '0;
  logic [15:0]   rd_data = '0;
  logic          eth_rx_req, rx_done, rx_overflow;
  logic [15:0]   eth_rx_buffer_data, rx_len, wr_data;
  logic [BW-1:0] eth_rx_buffer_addr;
  logic [2:0]    rx_sock;
  logic [10:0]   addr;
`ifdef W5300_RX_STATS_EN
  logic [31:0]   pkt_count;
  logic [15:0]   ovf_count;
`endif

  always #5 clk = ~clk;

  w5300_rx_arbiter #(.SOCKET_BASE(0), .NUM_SOCKETS(N), .ETH_RX_BUFFER_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .rx_irq(rx_irq), .buf_busy(buf_busy),
    .eth_rx_req(eth_rx_req), .eth_rx_buffer_data(eth_rx_buffer_data),
    .eth_rx_buffer_addr(eth_rx_buffer_addr), .rx_done(rx_done), .rx_sock(rx_sock),
    .rx_len(rx_len), .rx_overflow(rx_overflow), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .op_state(op_state)
`ifdef W5300_RX_STATS_EN
    , .pkt_count(pkt_count), .ovf_count(ovf_count)
`endif
  );

  typedef struct {int sock; int bytes; int tag;} pkt_t;
  pkt_t pend[$];

  int checks = 0, errors = 0;
  int cur = -1, wi = 0, last = N - 1, done_pend = 0, cyc = 0;
  int m_sock = 0, m_len = 0, m_ovf = 0, m_pkt = 0, m_ovf_cnt = 0;
  int n_done = 0, n_recv = 0, n_reads = 0;
  int log_addr[$], log_data[$], sock_log[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] fifor(int s); return 11'(1536 + 48 + s * 64); endfunction
  function automatic logic [10:0] crw(int s);   return 11'(512 + 2 + s * 64);   endfunction

  function automatic bit has_pend(int s);
    foreach (pend[i]) if (pend[i].sock == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_exp();
    for (int k = 1; k <= N; k++) if (has_pend((last + k) % N)) return (last + k) % N;
    return -1;
  endfunction

  // Socket/bus model: one FIFO pop per completed read, RECV retires the packet.
  initial forever begin
    int s, d, words;
    logic exp_req;
    logic [15:0] exp_d;
    int exp_a;
    bit ok;
    @(negedge clk);
    cyc++;
`ifdef W5300_RX_STATS_EN
    chk("pkt_count", pkt_count, m_pkt);
    chk("ovf_count", ovf_count, m_ovf_cnt);
`endif
    chk("rx_done", rx_done, done_pend);
    if (rx_done === 1'b1) sock_log.push_back(rx_sock);
    if (done_pend != 0) begin
      m_pkt++;
      if (m_ovf != 0) m_ovf_cnt++;
      n_done++;
    end
    done_pend = 0;
    chk("rx_sock", rx_sock, m_sock);
    chk("rx_len", rx_len, m_len);
    chk("rx_overflow", rx_overflow, m_ovf);
    ok = (addr == 11'h7FE);
    for (int i = 0; i < N; i++)
      if (cur < 0 ? has_pend(i) : pend[cur].sock == i) ok |= (addr == fifor(i));
    if (cur >= 0) ok |= (addr == crw(pend[cur].sock));
    chk("bus_addr", ok, 1);

    if (rst) begin
      op_state = 1'b0; rd_data = '0; rx_irq = '0;
      cur = -1; wi = 0; last = N - 1;
      m_sock = 0; m_len = 0; m_ovf = 0; m_pkt = 0; m_ovf_cnt = 0;
      pend.delete();
      continue;
    end

    rx_irq = '0;
    for (int i = 0; i < N; i++) if (has_pend(i)) rx_irq[i] = 1'b1;
    op_state = (cyc % 3) != 2;
    rd_data = '0;
    exp_req = 1'b0; exp_a = 0; exp_d = '0;
    s = -1;
    for (int i = 0; i < N; i++) if (addr == fifor(i)) s = i;
    if (op_state && s >= 0) begin
      if (cur < 0) begin
        chk("grant_sock", s, rr_exp());
        foreach (pend[i]) if (cur < 0 && pend[i].sock == s) cur = i;
        wi = 0;
      end
      if (cur >= 0) begin
        if (wi == 0) rd_data = 16'(pend[cur].bytes);
        else begin
          d = wi - 1;
          rd_data = {8'(pend[cur].tag), 8'(161 + d)};
          exp_req = (d < CAP); exp_a = d; exp_d = rd_data;
        end
        wi++; n_reads++;
      end
    end else if (op_state && cur >= 0 && addr == crw(pend[cur].sock)) begin
      words = (pend[cur].bytes + 1) / 2;
      chk("recv_wr_data", wr_data, 16'h0040);
      chk("fifo_reads", wi, 1 + words);
      m_sock = pend[cur].sock; m_len = pend[cur].bytes; m_ovf = (words > CAP);
      last = m_sock; done_pend = 1; n_recv++;
      pend.delete(cur); cur = -1;
    end
    #1;
    chk("eth_rx_req", eth_rx_req, exp_req);
    if (exp_req) begin
      chk("eth_rx_addr", eth_rx_buffer_addr, exp_a);
      chk("eth_rx_data", eth_rx_buffer_data, exp_d);
    end
    if (eth_rx_req === 1'b1) begin
      log_addr.push_back(int'(eth_rx_buffer_addr));
      log_data.push_back(int'(eth_rx_buffer_data));
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(int s, int b, int t);
    pkt_t p;
    p.sock = s; p.bytes = b; p.tag = t;
    pend.push_back(p);
  endtask

  task automatic wait_done(int target);
    for (int i = 0; i < 600 && n_done < target; i++) tick(1);
    chk("done_timeout", n_done >= target, 1);
  endtask

  initial begin
    int r0, rv;
    rst = 1'b1; tick(3);
    chk("rst_addr", addr, 11'h7FE);
    chk("rst_done", rx_done, 0);
    chk("rst_len", rx_len, 0);
    chk("rst_req", eth_rx_req, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;

    // 6 bytes on socket 0
    log_addr.delete(); log_data.delete();
    push(0, 6, 0); wait_done(1);
    chk("t1_req_cnt", log_addr.size(), 3);
    chk("t1_a0", log_addr[0], 0); chk("t1_a2", log_addr[2], 2);
    chk("t1_d0", log_data[0], 16'h00A1); chk("t1_d2", log_data[2], 16'h00A3);
    chk("t1_sock", rx_sock, 0); chk("t1_len", rx_len, 6); chk("t1_ovf", rx_overflow, 0);

    // odd length rounds up
    log_addr.delete(); r0 = n_reads;
    push(0, 5, 8'h10); wait_done(2);
    chk("t2_reads", n_reads - r0, 4); chk("t2_req_cnt", log_addr.size(), 3);
    chk("t2_len", rx_len, 5);

    // zero length: RECV with no data
    log_addr.delete(); rv = n_recv;
    push(0, 0, 0); wait_done(3);
    chk("t3_req_cnt", log_addr.size(), 0); chk("t3_recv", n_recv - rv, 1);
    chk("t3_len", rx_len, 0);

    // backpressure, then round robin with both irqs held
    rst = 1'b1; tick(2); rst = 1'b0;
    buf_busy = 1'b1; r0 = n_reads;
    push(0, 4, 8'h30); push(1, 4, 8'h31); push(0, 2, 8'h32); push(1, 2, 8'h33);
    tick(12);
    chk("busy_idle", addr, 11'h7FE); chk("busy_reads", n_reads - r0, 0);
    buf_busy = 1'b0; sock_log.delete();
    wait_done(7);
    chk("rr_cnt", sock_log.size(), 4);
    chk("rr_0", sock_log[0], 0); chk("rr_1", sock_log[1], 1);
    chk("rr_2", sock_log[2], 0); chk("rr_3", sock_log[3], 1);

    // overflow: 12 bytes into a 4-word buffer
    log_addr.delete(); r0 = n_reads;
    push(1, 12, 8'h40); wait_done(8); tick(1);
    chk("t5_reads", n_reads - r0, 7); chk("t5_req_cnt", log_addr.size(), 4);
    chk("t5_a3", log_addr[3], 3); chk("t5_ovf", rx_overflow, 1); chk("t5_sock", rx_sock, 1);
`ifdef W5300_RX_STATS_EN
    chk("t5_ovf_count", ovf_count, 1); chk("t5_pkt_count", pkt_count, 5);
`endif

    // exactly CAP words, then one past
    log_addr.delete();
    push(0, 8, 8'h50); wait_done(9);
    chk("t6_ovf_exact", rx_overflow, 0); chk("t6_req_exact", log_addr.size(), 4);
    log_addr.delete();
    push(0, 9, 8'h51); wait_done(10);
    chk("t6_ovf_plus", rx_overflow, 1); chk("t6_req_plus", log_addr.size(), 4);

    // reset in the middle of a FIFO drain
    rv = n_recv; r0 = n_reads;
    push(0, 12, 8'h60);
    for (int i = 0; i < 200 && n_reads - r0 < 3; i++) tick(1);
    chk("t7_in_fifo", n_reads - r0 >= 3, 1);
    rst = 1'b1; tick(1);
    chk("t7_addr", addr, 11'h7FE); chk("t7_req", eth_rx_req, 0);
    chk("t7_len", rx_len, 0); chk("t7_ovf", rx_overflow, 0); chk("t7_sock", rx_sock, 0);
    rst = 1'b0; tick(5);
    chk("t7_no_recv", n_recv - rv, 0); chk("t7_idle", addr, 11'h7FE);
    push(1, 2, 8'h70); wait_done(11);
    chk("t7_recover_len", rx_len, 2); chk("t7_recover_sock", rx_sock, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
